// File: rtl/pong_match_ctrl.sv
// Match sequencer for the two-paddle bouncing-block game: debounces the start key,
// runs the serve/rally/point/pause/over flow and keeps both players' scores and the speed gear.
module pong_match_ctrl #(
  parameter int unsigned TICK_DIV    = 25000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned SERVE_MS    = 1000,
  parameter int unsigned POINT_MS    = 500,
  parameter int unsigned WIN_SCORE   = 5,
  parameter int unsigned MAX_GEAR    = 6
) (
  input  logic       vga_clk,
  input  logic       sys_rst_n,
  input  logic       key_start_n,
  input  logic       hit_a,
  input  logic       hit_b,
  input  logic       miss_a,
  input  logic       miss_b,
  output logic       run_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [2:0] gear,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [2:0] game_state,
  output logic [1:0] winner
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_MS + 1);
  localparam int unsigned TMAX   = (SERVE_MS > POINT_MS) ? SERVE_MS : POINT_MS;
  localparam int unsigned TMR_W  = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_PAUSE = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  state_t state, state_nx;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  tick_cnt <= '0;
    else if (tick)   tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TICK_W'(1);
  end

  logic [1:0]       key_sync;
  logic             key_lvl, key_prev, armed, start_press, deb_done;
  logic [DEB_W-1:0] deb_cnt;

  assign key_lvl  = key_sync[1];
  assign deb_done = tick && (key_lvl == key_prev) && (deb_cnt == DEB_W'(DEBOUNCE_MS - 1));

  // The counter saturates at DEBOUNCE_MS so deb_done fires once per stable period;
  // armed records whether the last qualified level was high, i.e. a release was seen.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_sync    <= '1;
      key_prev    <= 1'b1;
      deb_cnt     <= '0;
      armed       <= 1'b1;
      start_press <= 1'b0;
    end else begin
      key_sync    <= {key_sync[0], key_start_n};
      key_prev    <= key_lvl;
      start_press <= deb_done && !key_lvl && armed;
      if (key_lvl != key_prev)
        deb_cnt <= '0;
      else if (tick && (deb_cnt != DEB_W'(DEBOUNCE_MS)))
        deb_cnt <= deb_cnt + DEB_W'(1);
      if (deb_done)
        armed <= key_lvl;
    end
  end

  logic [TMR_W-1:0] timer, timer_nx;
  logic [3:0]       score_a_nx, score_b_nx, inc_a, inc_b;
  logic [2:0]       gear_nx;
  logic [1:0]       winner_nx;
  logic             dir_nx;

  assign inc_a = score_a + 4'd1;
  assign inc_b = score_b + 4'd1;

  always_comb begin
    state_nx   = state;
    score_a_nx = score_a;
    score_b_nx = score_b;
    gear_nx    = gear;
    winner_nx  = winner;
    dir_nx     = serve_dir;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_press) begin
          score_a_nx = '0;
          score_b_nx = '0;
          winner_nx  = '0;
          gear_nx    = 3'd1;
          dir_nx     = 1'b1;
          state_nx   = S_SERVE;
        end
      end
      S_SERVE: begin
        if (tick && (timer == TMR_W'(SERVE_MS - 1))) state_nx = S_PLAY;
      end
      S_PLAY: begin
        if (miss_a && miss_b) begin
          state_nx = S_POINT;
          gear_nx  = 3'd1;
        end else if (miss_a) begin
          score_b_nx = inc_b;
          dir_nx     = 1'b1;
          if (inc_b == 4'(WIN_SCORE)) begin
            state_nx  = S_OVER;
            winner_nx = 2'd2;
          end else begin
            state_nx = S_POINT;
            gear_nx  = 3'd1;
          end
        end else if (miss_b) begin
          score_a_nx = inc_a;
          dir_nx     = 1'b0;
          if (inc_a == 4'(WIN_SCORE)) begin
            state_nx  = S_OVER;
            winner_nx = 2'd1;
          end else begin
            state_nx = S_POINT;
            gear_nx  = 3'd1;
          end
        end else if (hit_a || hit_b) begin
          if (gear != 3'(MAX_GEAR)) gear_nx = gear + 3'd1;
        end else if (start_press) begin
          state_nx = S_PAUSE;
        end
      end
      S_POINT: begin
        if (tick && (timer == TMR_W'(POINT_MS - 1))) state_nx = S_SERVE;
      end
      S_PAUSE: begin
        if (start_press) state_nx = S_PLAY;
      end
      default: state_nx = S_IDLE;
    endcase

    timer_nx = timer;
    if (state_nx != state) timer_nx = '0;
    else if (tick)         timer_nx = timer + TMR_W'(1);
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      run_en     <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b1;
      gear       <= 3'd1;
      score_a    <= '0;
      score_b    <= '0;
      winner     <= '0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      run_en     <= (state_nx == S_PLAY);
      ball_reset <= (state_nx == S_SERVE) && (state != S_SERVE);
      serve_dir  <= dir_nx;
      gear       <= gear_nx;
      score_a    <= score_a_nx;
      score_b    <= score_b_nx;
      winner     <= winner_nx;
    end
  end

  assign game_state = state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scoreboard bench for pong_match_ctrl: a game-level model queues the expected output
// snapshots; a negedge monitor pops one per observed output change and checks timing.
module tb_pong_match_ctrl;

  localparam int TD = 4, DEB = 2, SMS = 3, PMS = 2, WIN = 2, MG = 6;

  logic clk = 1'b0, rst_n = 1'b1, key_n = 1'b1;
  logic ha = 1'b0, hb = 1'b0, ma = 1'b0, mb = 1'b0;
  logic       run_en, ball_reset, serve_dir;
  logic [2:0] gear, game_state;
  logic [3:0] score_a, score_b;
  logic [1:0] winner;

  pong_match_ctrl #(
    .TICK_DIV(TD), .DEBOUNCE_MS(DEB), .SERVE_MS(SMS),
    .POINT_MS(PMS), .WIN_SCORE(WIN), .MAX_GEAR(MG)
  ) dut (
    .vga_clk(clk), .sys_rst_n(rst_n), .key_start_n(key_n),
    .hit_a(ha), .hit_b(hb), .miss_a(ma), .miss_b(mb),
    .run_en(run_en), .ball_reset(ball_reset), .serve_dir(serve_dir),
    .gear(gear), .score_a(score_a), .score_b(score_b),
    .game_state(game_state), .winner(winner)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       run;
    logic       dir;
    logic [2:0] gear;
    logic [3:0] sa;
    logic [3:0] sb;
    logic [1:0] win;
  } snap_t;

  snap_t cur, last_seen, last_push, rst_snap, e;
  snap_t exp_q[$];
  int checks = 0, errors = 0;
  int m_st, m_sa, m_sb, m_gear, m_dir, m_win;

  assign cur = {game_state, run_en, serve_dir, gear, score_a, score_b, winner};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st = 3'(m_st); s.run = (m_st == 2); s.dir = 1'(m_dir); s.gear = 3'(m_gear);
    s.sa = 4'(m_sa); s.sb = 4'(m_sb); s.win = 2'(m_win);
    return s;
  endfunction

  task automatic push();
    snap_t s = model_snap();
    if (s != last_push) begin
      exp_q.push_back(s);
      last_push = s;
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_sa = 0; m_sb = 0; m_gear = 1; m_dir = 1; m_win = 0;
    push();
  endtask

  task automatic model_start();
    m_sa = 0; m_sb = 0; m_win = 0; m_gear = 1; m_dir = 1;
    m_st = 1; push();
    m_st = 2; push();
  endtask

  task automatic model_play(input bit a_m, input bit b_m, input bit a_h, input bit b_h);
    int w = 0;
    if (a_m || b_m) begin
      if (a_m && !b_m) begin m_sb++; m_dir = 1; if (m_sb == WIN) w = 2; end
      if (b_m && !a_m) begin m_sa++; m_dir = 0; if (m_sa == WIN) w = 1; end
      if (w != 0) begin
        m_win = w; m_st = 5; push();
      end else begin
        m_gear = 1; m_st = 3; push();
        m_st = 1; push();
        m_st = 2; push();
      end
    end else if (a_h || b_h) begin
      m_gear = (m_gear + 1 > MG) ? MG : m_gear + 1;
      push();
    end
  endtask

  task automatic pulse(input logic a_m, input logic b_m, input logic a_h, input logic b_h);
    ma = a_m; mb = b_m; ha = a_h; hb = b_h;
    @(negedge clk);
    ma = 1'b0; mb = 1'b0; ha = 1'b0; hb = 1'b0;
  endtask

  task automatic press();
    key_n = 1'b0;
    repeat (3 * TD + 2) @(negedge clk);
    key_n = 1'b1;
    repeat (3 * TD + 2) @(negedge clk);
  endtask

  task automatic wait_state(input int s, input string name);
    int n = 0;
    while (game_state != 3'(s) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(game_state), s);
  endtask

  int cyc, svc, ptc;
  logic [2:0] prev_st = 3'd0;
  logic tick_now;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cur != last_seen) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL snapshot_unexpected actual=0x%0h expected=none at %0t", cur, $time);
      end else begin
        e = exp_q.pop_front();
        check("snapshot", int'(cur), int'(e));
      end
      last_seen = cur;
    end
    if (rst_n) begin
      tick_now = ((cyc % TD) == TD - 1);
      if (game_state == 3'd1 && prev_st != 3'd1) check("ball_reset_on_serve", int'(ball_reset), 1);
      else if (ball_reset)                        check("ball_reset_stray", int'(ball_reset), 0);
      if (game_state == 3'd2 && prev_st == 3'd1)  check("serve_ticks", svc, SMS);
      if (game_state == 3'd1 && prev_st == 3'd3)  check("point_ticks", ptc, PMS);
      if (game_state == 3'd1) begin
        if (prev_st != 3'd1) svc = 0;
        if (tick_now) svc++;
      end
      if (game_state == 3'd3) begin
        if (prev_st != 3'd3) ptc = 0;
        if (tick_now) ptc++;
      end
    end
    prev_st = game_state;
  end

  initial begin
    int r, h, m;
    m_st = 0; m_sa = 0; m_sb = 0; m_gear = 1; m_dir = 1; m_win = 0;
    rst_snap  = model_snap();
    last_push = rst_snap;
    last_seen = rst_snap;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_snapshot", int'(cur), int'(rst_snap));
    check("reset_ball_reset", int'(ball_reset), 0);
    rst_n = 1'b1;

    // short glitch on the key must not start a match
    key_n = 1'b0;
    repeat (TD) @(negedge clk);
    key_n = 1'b1;
    repeat (6 * TD) @(negedge clk);
    check("idle_after_glitch", int'(game_state), 0);

    model_start();
    press();
    wait_state(2, "wait_play_start");

    repeat (7) begin
      model_play(0, 0, 1, 0);
      pulse(0, 0, 1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    check("gear_saturated", int'(gear), MG);

    model_play(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    wait_state(2, "wait_play_after_miss_a");
    model_play(0, 0, 1, 1);
    pulse(0, 0, 1, 1);
    @(negedge clk);
    check("gear_dual_hit", int'(gear), 2);

    model_play(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    wait_state(2, "wait_play_rally2");
    model_play(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    wait_state(5, "wait_over");
    check("winner_a", int'(winner), 1);
    model_start();
    press();
    wait_state(2, "wait_play_rematch");

    model_play(0, 0, 1, 0);
    pulse(0, 0, 1, 0);
    model_play(1, 0, 0, 1);
    pulse(1, 0, 0, 1);
    wait_state(2, "wait_play_after_miss_hit");
    model_play(1, 1, 0, 0);
    pulse(1, 1, 0, 0);
    wait_state(2, "wait_play_after_double_miss");

    m_st = 4; push();
    press();
    wait_state(4, "wait_pause");
    pulse(0, 0, 1, 0);
    m_st = 2; push();
    press();
    wait_state(2, "wait_resume");
    model_play(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    @(negedge clk);
    model_reset();
    rst_n = 1'b0;
    #1;
    check("reset_async_snapshot", int'(cur), int'(rst_snap));
    check("reset_async_ball_reset", int'(ball_reset), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int it = 0; it < 30; it++) begin
      if (m_st == 0 || m_st == 5) begin
        model_start();
        press();
      end
      wait_state(2, "wait_play_random");
      r = $urandom_range(0, 9);
      h = $urandom_range(1, 3);
      m = $urandom_range(0, 1);
      case (r)
        5: begin model_play(1, 0, 0, 0); pulse(1, 0, 0, 0); end
        6: begin model_play(0, 1, 0, 0); pulse(0, 1, 0, 0); end
        7: begin model_play(1, 1, 0, 0); pulse(1, 1, 0, 0); end
        8: begin
          model_play(m == 0, m == 1, h[0], h[1]);
          pulse(m == 0, m == 1, h[0], h[1]);
        end
        9: begin
          m_st = 4; push();
          press();
          wait_state(4, "wait_pause_random");
          pulse(m == 0, m == 1, h[0], h[1]);
          m_st = 2; push();
          press();
        end
        default: begin model_play(0, 0, h[0], h[1]); pulse(0, 0, h[0], h[1]); end
      endcase
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (40) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
